// File: rtl/shooter_game_core_if.sv
// Signal bundle between the shooter game core and its board-level
// surroundings: player controls in, LED matrix / score display out.
interface shooter_game_core_if #(
  parameter int COLS = 8,
  parameter int ROWS = 8
);
  logic            left0;
  logic            right0;
  logic            left1;
  logic            right1;
  logic            att;
  logic [ROWS-1:0] row_sel;
  logic [COLS-1:0] col_n;
  logic [7:0]      score_bcd;
  logic [6:0]      seg_tens;
  logic [6:0]      seg_ones;
  logic [3:0]      miss_cnt;
  logic            game_over;

  modport master (
    output left0, right0, left1, right1, att,
    input  row_sel, col_n, score_bcd, seg_tens, seg_ones, miss_cnt, game_over
  );

  modport slave (
    input  left0, right0, left1, right1, att,
    output row_sel, col_n, score_bcd, seg_tens, seg_ones, miss_cnt, game_over
  );
endinterface

// File: rtl/shooter_game_core.sv
// Shooter/catcher LED-matrix game: a shooter on rows 0-1 fires bullets that
// fall through the field rows; the catcher on the last row scores a hit when
// it sits under the bullet, otherwise a miss. Enough misses freeze the game
// until the next fire edge restarts it. The matrix is row-scanned.
module shooter_game_core #(
  parameter int COLS     = 8,
  parameter int ROWS     = 8,
  parameter int MOVE_DIV = 2_000_000,
  parameter int STEP_DIV = 15_000_000,
  parameter int SCAN_DIV = 10_000,
  parameter int MAX_MISS = 3
) (
  input  logic               clk,
  input  logic               rst,
  shooter_game_core_if.slave bus
);
  localparam int SHW = $clog2(COLS);
  localparam int RW  = $clog2(ROWS);
  localparam int MVW = $clog2(MOVE_DIV + 1);
  localparam int STW = $clog2(STEP_DIV + 1);
  localparam int SCW = $clog2(SCAN_DIV + 1);
  localparam logic [SHW-1:0] SH_RST = SHW'((COLS - 3) / 2);
  localparam logic [SHW-1:0] CT_RST = SHW'((COLS - 1) / 2);
  localparam logic [SHW-1:0] SH_MAX = SHW'(COLS - 3);
  localparam logic [SHW-1:0] CT_MAX = SHW'(COLS - 1);

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  logic [MVW-1:0]  mv_cnt_q, mv_cnt_d;
  logic [STW-1:0]  st_cnt_q, st_cnt_d;
  logic [SCW-1:0]  sc_cnt_q, sc_cnt_d;
  logic            mv_tick, st_tick, sc_tick;
  logic [SHW-1:0]  sh_q, sh_d, ct_q, ct_d;
  logic [COLS-1:0] fld_q [2:ROWS-2];
  logic [COLS-1:0] fld_d [2:ROWS-2];
  logic [7:0]      score_q, score_d;
  logic [3:0]      miss_q, miss_d;
  logic            go_q, go_d;
  logic            att_prev_q, att_prev_d;
  logic            fire_edge, hit, miss_ev;
  logic [RW-1:0]   idx_q, idx_d;
  logic [ROWS-1:0] row_sel_q, row_sel_d;
  logic [COLS-1:0] col_n_q, col_n_d;
  logic [6:0]      seg_t_q, seg_t_d, seg_o_q, seg_o_d;
  logic [COLS-1:0] disp [ROWS];

  // Free-running tick dividers; each tick is a one-cycle enable.
  always_comb begin
    mv_tick  = (mv_cnt_q == MVW'(MOVE_DIV - 1));
    st_tick  = (st_cnt_q == STW'(STEP_DIV - 1));
    sc_tick  = (sc_cnt_q == SCW'(SCAN_DIV - 1));
    mv_cnt_d = mv_tick ? '0 : mv_cnt_q + MVW'(1);
    st_cnt_d = st_tick ? '0 : st_cnt_q + STW'(1);
    sc_cnt_d = sc_tick ? '0 : sc_cnt_q + SCW'(1);
  end

  // Game rules: bullet fall and resolution, fire, moves, scoring, restart.
  always_comb begin
    att_prev_d = bus.att;
    fire_edge  = bus.att & ~att_prev_q;
    sh_d       = sh_q;
    ct_d       = ct_q;
    fld_d      = fld_q;
    score_d    = score_q;
    miss_d     = miss_q;
    go_d       = go_q;
    hit        = 1'b0;
    miss_ev    = 1'b0;
    if (go_q) begin
      // The restarting edge does not also fire a bullet.
      if (fire_edge) begin
        for (int r = 2; r <= ROWS - 2; r++) fld_d[r] = '0;
        sh_d    = SH_RST;
        ct_d    = CT_RST;
        score_d = 8'h00;
        miss_d  = 4'd0;
        go_d    = 1'b0;
      end
    end else begin
      if (st_tick) begin
        if (|fld_q[ROWS-2]) begin
          hit     = fld_q[ROWS-2][ct_q];
          miss_ev = ~fld_q[ROWS-2][ct_q];
        end
        for (int r = ROWS - 2; r >= 3; r--) fld_d[r] = fld_q[r-1];
        fld_d[2] = '0;
      end
      // Row 2 is checked after the shift so a fire on a step edge lands.
      if (fire_edge && (fld_d[2] == '0)) fld_d[2][sh_q + SHW'(1)] = 1'b1;
      if (mv_tick) begin
        if (bus.right0 && !bus.left0 && (sh_q != SH_MAX)) sh_d = sh_q + SHW'(1);
        else if (bus.left0 && !bus.right0 && (sh_q != '0)) sh_d = sh_q - SHW'(1);
        if (bus.right1 && !bus.left1 && (ct_q != CT_MAX)) ct_d = ct_q + SHW'(1);
        else if (bus.left1 && !bus.right1 && (ct_q != '0)) ct_d = ct_q - SHW'(1);
      end
      if (hit) score_d = bcd_inc(score_q);
      if (miss_ev) begin
        miss_d = miss_q + 4'd1;
        if (miss_d == 4'(MAX_MISS)) go_d = 1'b1;
      end
    end
  end

  // Matrix image, row scan and 7-segment decode feeding the output registers.
  always_comb begin
    for (int r = 0; r < ROWS; r++) disp[r] = '0;
    disp[0]      = COLS'(7) << sh_q;
    disp[1]      = COLS'(1) << (sh_q + SHW'(1));
    disp[ROWS-1] = COLS'(1) << ct_q;
    for (int r = 2; r <= ROWS - 2; r++) disp[r] = fld_q[r];
    idx_d = idx_q;
    if (sc_tick) idx_d = (idx_q == RW'(ROWS - 1)) ? '0 : idx_q + RW'(1);
    row_sel_d = ROWS'(1) << idx_d;
    col_n_d   = ~disp[idx_d];
    seg_t_d   = seg7(score_q[7:4]);
    seg_o_d   = seg7(score_q[3:0]);
  end

  // State registers; reset drops bullets and pending ticks at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mv_cnt_q   <= '0;
      st_cnt_q   <= '0;
      sc_cnt_q   <= '0;
      sh_q       <= SH_RST;
      ct_q       <= CT_RST;
      for (int r = 2; r <= ROWS - 2; r++) fld_q[r] <= '0;
      score_q    <= 8'h00;
      miss_q     <= 4'd0;
      go_q       <= 1'b0;
      att_prev_q <= 1'b0;
      idx_q      <= '0;
      row_sel_q  <= ROWS'(1);
      col_n_q    <= ~(COLS'(7) << SH_RST);
      seg_t_q    <= 7'b1111110;
      seg_o_q    <= 7'b1111110;
    end else begin
      mv_cnt_q   <= mv_cnt_d;
      st_cnt_q   <= st_cnt_d;
      sc_cnt_q   <= sc_cnt_d;
      sh_q       <= sh_d;
      ct_q       <= ct_d;
      for (int r = 2; r <= ROWS - 2; r++) fld_q[r] <= fld_d[r];
      score_q    <= score_d;
      miss_q     <= miss_d;
      go_q       <= go_d;
      att_prev_q <= att_prev_d;
      idx_q      <= idx_d;
      row_sel_q  <= row_sel_d;
      col_n_q    <= col_n_d;
      seg_t_q    <= seg_t_d;
      seg_o_q    <= seg_o_d;
    end
  end

  assign bus.row_sel   = row_sel_q;
  assign bus.col_n     = col_n_q;
  assign bus.score_bcd = score_q;
  assign bus.seg_tens  = seg_t_q;
  assign bus.seg_ones  = seg_o_q;
  assign bus.miss_cnt  = miss_q;
  assign bus.game_over = go_q;
endmodule

// File: doc/shooter_game_core.md
SHOOTER_GAME_CORE -- requirements
Module: shooter_game_core

Interface
REQ-001 Parameter: COLS, 8, matrix columns (>=4).
REQ-002 Parameter: ROWS, 8, matrix rows (>=5); row 0 is shooter body, row 1 barrel, rows 2..ROWS-2 bullet field, row ROWS-1 catcher.
REQ-003 Parameter: MOVE_DIV, 2_000_000, clk cycles per move tick.
REQ-004 Parameter: STEP_DIV, 15_000_000, clk cycles per bullet-step tick.
REQ-005 Parameter: SCAN_DIV, 10_000, clk cycles per display row advance.
REQ-006 Parameter: MAX_MISS, 3, misses that end the game (1..15).
REQ-007 Port: clk  input  1  single system clock, all logic on rising edge.
REQ-008 Port: rst  input  1  asynchronous, active-high reset.
REQ-009 Ports: left0, right0, left1, right1  input  1 each  held-level move requests for shooter (0) and catcher (1), already synchronous to clk.
REQ-010 Port: att  input  1  fire request, level, synchronous to clk.
REQ-011 Port: row_sel  output  ROWS  one-hot active-high row strobe; bit r selects row r.
REQ-012 Port: col_n  output  COLS  active-low column data for selected row; bit c low = LED (r,c) lit.
REQ-013 Port: score_bcd  output  8  two-digit BCD score, [7:4] tens, [3:0] ones.
REQ-014 Port: seg_tens, seg_ones  output  7 each  segments abcdefg, active-high; 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
REQ-015 Port: miss_cnt  output  4  misses so far.
REQ-016 Port: game_over  output  1  high while game frozen.

Function
REQ-017 Three free-running counters SHALL each assert a one-cycle tick every MOVE_DIV, STEP_DIV, SCAN_DIV clk cycles; no derived clocks.
REQ-018 Shooter position sh (0..COLS-3): row 0 lit at cols sh..sh+2, row 1 lit at col sh+1 (barrel).
REQ-019 Catcher position ct (0..COLS-1): row ROWS-1 lit at col ct only.
REQ-020 On move tick: right held alone -> position +1, left held alone -> position -1; both or neither -> hold; saturate at bounds, never wrap.
REQ-021 Fire: rising edge of att (registered previous value) deposits bullet at col sh+1 in row 2, only if row 2 is empty (after any same-cycle step shift); otherwise fire dropped.
REQ-022 On step tick: row r+1 <= row r for r=2..ROWS-3; row 2 cleared unless same-cycle fire.
REQ-023 Bullet in row ROWS-2 at step tick is resolved and removed: col == ct -> hit, else miss; at most one bullet per row by REQ-021.
REQ-024 Hit: score_bcd +1 in BCD; 09->10; 99 wraps to 00.
REQ-025 Miss: miss_cnt +1; when it reaches MAX_MISS, game_over <= 1 same edge.
REQ-026 While game_over: moves, steps, fires, scoring frozen; display and scan continue.
REQ-027 att rising edge during game_over: clears field, score_bcd=00, miss_cnt=0, game_over=0, positions to reset values; no bullet fired on that edge.
REQ-028 Scan: on scan tick row index advances, wraps ROWS-1 -> 0; row_sel and col_n registered, col_n = ~(row content) of current index.
REQ-029 seg_tens/seg_ones registered decode of score_bcd, one cycle latency.

Reset
REQ-030 On rst: sh=(COLS-3)/2, ct=(COLS-1)/2, field empty, score_bcd=8'h00, miss_cnt=0, game_over=0, all tick counters 0, att edge register 0, scan index 0, row_sel=1, col_n=~row0 content, seg_tens=seg_ones=1111110.
REQ-031 rst asserted mid-game SHALL discard in-flight bullets and pending ticks immediately, no glitch-free guarantee needed on outputs.

Verification (COLS=ROWS=8, MOVE_DIV=2, STEP_DIV=4, SCAN_DIV=1, MAX_MISS=3)
REQ-032 Reset, hold att low -> sh=2, ct=3, row_sel cycles 01,02,04..80,01 one per clk; row 0 col_n=11100011.
REQ-033 One att pulse, ct=3 -> after 5 step ticks score_bcd=01, seg_ones=0110000, miss_cnt=0.
REQ-034 Hold left0 for 20 move ticks -> sh=0, stays 0; hold left0+right0 -> sh unchanged.
REQ-035 Fire with ct=0, three times -> miss_cnt=3, game_over=1; further att edge clears to score 00, miss 0, game_over 0.
REQ-036 Two att pulses before one step tick -> second dropped, only one hit/miss resolved.
REQ-037 Assert rst with bullets in rows 3-5 and score 07 -> all REQ-030 values next sample, field empty.
